fibonacci_rsp_buf: RTL and testbench

FIBONACCI_RSP_BUF -- requirements
Module: fibonacci_rsp_buf

---
 rtl/fibonacci_pkg.sv | 28 ++
 rtl/fibonacci_rsp_fifo.sv | 94 +++++++++
 rtl/fibonacci_rsp_buf.sv | 158 +++++++++++++++
 tb/tb_fibonacci_rsp_buf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fibonacci_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_pkg
// Description : Shared types for the Fibonacci response path. It holds the
//               result interface struct, the response-buffer state encoding
//               and the default response-buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package fibonacci_pkg;

   // Default number of results held by fibonacci_rsp_buf
   localparam int RSP_BUF_DEPTH = 4;

   // Result interface produced by the Fibonacci core
   typedef struct packed {
      logic       valid;
      logic [7:0] result;
   } t_output_interface;

   // Occupancy state of the response buffer
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } t_rsp_buf_state;

endpackage : fibonacci_pkg
`default_nettype wire

// File: rtl/fibonacci_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_rsp_fifo
// Description : Circular result store with write/read pointers and an
//               occupancy counter. The head entry and its valid flag are
//               registered, and they are computed from next-state values so
//               that a pop is reflected on the following cycle.
// Ports       : clk, rst (async, active-high)
//               flush_i      - clear pointers and count
//               push_i       - write wdata_i (caller guarantees space)
//               pop_i        - discard head (caller guarantees head_valid_o)
//               wdata_i      - data to write
//               count_o      - occupancy
//               head_valid_o - occupancy != 0
//               head_data_o  - oldest entry, 8'h00 when empty
// Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_rsp_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [7:0]               wdata_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     head_valid_o,
   output logic [7:0]               head_data_o
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          head_valid_q, head_valid_d;
   logic [7:0]    head_data_q, head_data_d;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      head_valid_d = 1'b0;
      head_data_d  = 8'h00;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
         if (count_d != '0) begin
            head_valid_d = 1'b1;
            // The slot being written becomes head when the buffer drains to it
            if (push_i && (wr_ptr_q == rd_ptr_d))
               head_data_d = wdata_i;
            else
               head_data_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_valid_q <= 1'b0;
         head_data_q  <= 8'h00;
      end else begin
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_valid_q <= head_valid_d;
         head_data_q  <= head_data_d;
      end
   end

   assign count_o      = count_q;
   assign head_valid_o = head_valid_q;
   assign head_data_o  = head_data_q;

endmodule : fibonacci_rsp_fifo
`default_nettype wire

// File: rtl/fibonacci_rsp_buf.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_rsp_buf
// Description : Response buffer for Fibonacci results. It captures a result
//               on each low->high edge of in_if.valid, queues it in a
//               circular FIFO and presents the oldest entry with a
//               valid/ready handshake. Results that arrive while the buffer
//               is full are dropped and counted.
// Ports       : clk, rst (async, active-high)
//               in_if     - {valid, result[7:0]} from the core
//               flush     - synchronous clear of buffered results
//               out_ready - consumer takes out_data this cycle
//               out_valid / out_data - oldest result (8'h00 when invalid)
//               count, full          - occupancy, count == DEPTH
//               overflow, drop_cnt   - sticky drop flag, saturating counter
//               sum (optional)       - wrapping 12-bit sum of accepted data
// Config      : define FIBONACCI_RSP_BUF_SUM_EN to add the sum output
// Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_rsp_buf
   import fibonacci_pkg::*;
#(
   parameter int DEPTH  = RSP_BUF_DEPTH,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  t_output_interface        in_if,
   input  logic                     flush,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_cnt
`ifdef FIBONACCI_RSP_BUF_SUM_EN
  ,output logic [11:0]              sum
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] c_cnt_one  = CW'(1);
   localparam logic [CW-1:0] c_cnt_last = CW'(DEPTH - 1);

   t_rsp_buf_state  state_q, state_d;
   logic            in_valid_q;
   logic            armed_q;
   logic            cap_valid_q;
   logic [7:0]      cap_data_q;
   logic            overflow_q;
   logic [DROP_W-1:0] drop_cnt_q;

   logic            w_rise;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic            w_full;
   logic [CW-1:0]   w_count;

   // armed_q blocks a valid that is already high when reset releases from
   // being taken as a rising edge; it needs to see valid low first.
   assign w_rise = in_if.valid & ~in_valid_q & armed_q;
   assign w_pop  = out_valid & out_ready & ~flush;
   assign w_push = cap_valid_q & ~flush & ((state_q != FULL) | w_pop);
   assign w_drop = cap_valid_q & ~flush & (state_q == FULL) & ~w_pop;

   // ---------------- edge detect / capture ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_valid_q  <= 1'b0;
         armed_q     <= 1'b0;
         cap_valid_q <= 1'b0;
         cap_data_q  <= 8'h00;
      end else begin
         in_valid_q  <= in_if.valid;
         armed_q     <= armed_q | ~in_if.valid;
         cap_valid_q <= w_rise & ~flush;
         if (w_rise) cap_data_q <= in_if.result;
      end
   end

   // ---------------- storage ----------------
   fibonacci_rsp_fifo #(
      .DEPTH        (DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .push_i       (w_push),
      .pop_i        (w_pop),
      .wdata_i      (cap_data_q),
      .count_o      (w_count),
      .head_valid_o (out_valid),
      .head_data_o  (out_data)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY:   if (w_push) state_d = PARTIAL;
            PARTIAL: begin
               if (w_push && !w_pop && (w_count == c_cnt_last))
                  state_d = FULL;
               else if (w_pop && !w_push && (w_count == c_cnt_one))
                  state_d = EMPTY;
            end
            FULL:    if (w_pop && !w_push) state_d = PARTIAL;
            default: state_d = EMPTY;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_full = (state_q == FULL);
   end

   // ---------------- drop accounting (not cleared by flush) ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (w_drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
   end

`ifdef FIBONACCI_RSP_BUF_SUM_EN
   logic [11:0] sum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         sum_q <= 12'h000;
      else if (flush)  sum_q <= 12'h000;
      else if (w_push) sum_q <= sum_q + {4'h0, cap_data_q};
   end

   assign sum = sum_q;
`endif

   assign count    = w_count;
   assign full     = w_full;
   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

endmodule : fibonacci_rsp_buf
`default_nettype wire

// File: tb/tb_fibonacci_rsp_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fibonacci_rsp_buf
// Description : Directed self-checking bench for fibonacci_rsp_buf
//               (DEPTH=4, DROP_W=8). Inputs change 1 time unit after the
//               rising edge; outputs are sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fibonacci_rsp_buf;
   import fibonacci_pkg::*;

   logic              clk;
   logic              rst;
   t_output_interface in_if;
   logic              flush;
   logic              out_ready;
   logic              out_valid;
   logic [7:0]        out_data;
   logic [2:0]        count;
   logic              full;
   logic              overflow;
   logic [7:0]        drop_cnt;
`ifdef FIBONACCI_RSP_BUF_SUM_EN
   logic [11:0]       sum;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   fibonacci_rsp_buf #(
      .DEPTH     (4),
      .DROP_W    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_if     (in_if),
      .flush     (flush),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .count     (count),
      .full      (full),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
`ifdef FIBONACCI_RSP_BUF_SUM_EN
     ,.sum       (sum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle valid pulse followed by one idle cycle; on return the
   // result has been pushed (if space) and is visible if it is the head.
   task automatic pulse(input logic [7:0] d);
      in_if.valid  = 1'b1;
      in_if.result = d;
      tick();
      in_if.valid  = 1'b0;
      tick();
   endtask

   logic [7:0] seq_fib [8] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
   logic [7:0] seq_ovf [6] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
   logic [7:0] exp_drn [4];

   initial begin
      rst       = 1'b1;
      in_if     = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      // ---- reset state ----
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_count",     count,     0);
      check("rst_full",      full,      0);
      check("rst_overflow",  overflow,  0);
      check("rst_drop_cnt",  drop_cnt,  0);
      rst = 1'b0;
      tick();

      // ---- in-order stream, one cycle capture-to-valid ----
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_if.valid  = 1'b1;
         in_if.result = seq_fib[i];
         tick();
         if (i == 0) check("seq_no_bypass", out_valid, 0);
         in_if.valid = 1'b0;
         tick();
         check("seq_valid", out_valid, 1);
         check("seq_data",  out_data,  seq_fib[i]);
      end
      tick();
      check("seq_drained_valid", out_valid, 0);
      check("seq_drained_data",  out_data,  0);
      check("seq_overflow",      overflow,  0);

      // ---- valid held high: single capture ----
      out_ready    = 1'b0;
      in_if.valid  = 1'b1;
      in_if.result = 8'd13;
      repeat (20) tick();
      in_if.valid = 1'b0;
      tick();
      check("hold_count", count,    1);
      check("hold_data",  out_data, 13);
      out_ready = 1'b1;
      tick();
      check("hold_drained", count, 0);

      // ---- overflow with consumer stalled ----
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) pulse(seq_ovf[i]);
      check("ovf_full",     full,     1);
      check("ovf_count",    count,    4);
      check("ovf_flag",     overflow, 1);
      check("ovf_drop_cnt", drop_cnt, 2);
      out_ready = 1'b1;
      exp_drn = '{8'd1, 8'd2, 8'd3, 8'd5};
      for (int i = 0; i < 4; i++) begin
         check("ovf_drain", out_data, exp_drn[i]);
         tick();
      end
      check("ovf_empty", count, 0);

      // ---- push and pop together while full ----
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) pulse(seq_ovf[i]);
      check("pp_full_before", full, 1);
      in_if.valid  = 1'b1;
      in_if.result = 8'd21;
      tick();
      in_if.valid = 1'b0;
      out_ready   = 1'b1;
      tick();
      out_ready = 1'b0;
      check("pp_count",    count,    4);
      check("pp_drop_cnt", drop_cnt, 2);
      check("pp_head",     out_data, 2);
      out_ready = 1'b1;
      exp_drn = '{8'd2, 8'd3, 8'd5, 8'd21};
      for (int i = 0; i < 4; i++) begin
         check("pp_drain", out_data, exp_drn[i]);
         tick();
      end
      check("pp_empty", out_valid, 0);

      // ---- flush with simultaneous push ----
      out_ready = 1'b0;
      pulse(8'd8);
      pulse(8'd13);
      check("fl_count_before", count, 2);
      flush        = 1'b1;
      in_if.valid  = 1'b1;
      in_if.result = 8'd21;
      tick();
      flush       = 1'b0;
      in_if.valid = 1'b0;
      check("fl_count",     count,     0);
      check("fl_out_valid", out_valid, 0);
      check("fl_overflow",  overflow,  1);
      check("fl_drop_cnt",  drop_cnt,  2);
`ifdef FIBONACCI_RSP_BUF_SUM_EN
      check("fl_sum", sum, 0);
`endif
      tick();
      check("fl_push_discarded", count, 0);

      // ---- asynchronous reset mid-operation ----
      pulse(8'd1);
      pulse(8'd2);
      pulse(8'd3);
      check("ar_count_before", count, 3);
      in_if.valid  = 1'b1;
      in_if.result = 8'd99;
      #2 rst = 1'b1;
      #1;
      check("ar_count",     count,     0);
      check("ar_out_valid", out_valid, 0);
      check("ar_out_data",  out_data,  0);
      check("ar_overflow",  overflow,  0);
      check("ar_drop_cnt",  drop_cnt,  0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("ar_no_capture", count, 0);
      in_if.valid = 1'b0;
      tick();
      pulse(8'd8);
      pulse(8'd13);
      pulse(8'd21);
      check("ar_count_after", count,    3);
      check("ar_head_after",  out_data, 8);
`ifdef FIBONACCI_RSP_BUF_SUM_EN
      check("ar_sum", sum, 42);
`endif

      // ---- drop counter saturation ----
      pulse(8'd34);
      check("sat_full", full, 1);
      for (int i = 0; i < 256; i++) pulse(8'(i));
      check("sat_drop_cnt", drop_cnt, 255);
      check("sat_count",    count,    4);
      check("sat_head",     out_data, 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fibonacci_rsp_buf
`default_nettype wire
